// File: rtl/drum_mix_i2s_if.sv
// -----------------------------------------------------------------------------
// drum_mix_i2s_if
//
// Purpose: groups the four signals that run from the drum mixer to the
// Pmod I2S DAC so they travel as one bundle.
//
// Signals:
//   mclk  master clock to the DAC (clk/4)
//   sck   serial bit clock (clk/16)
//   lrck  word select; 0 = left half of the frame, 1 = right half
//   sdin  serial audio data, MSB first
//
// Modports:
//   master  driven by the mixer (all signals are outputs)
//   slave   seen by the DAC or a monitor (all signals are inputs)
// -----------------------------------------------------------------------------
interface drum_mix_i2s_if;
    logic mclk;
    logic sck;
    logic lrck;
    logic sdin;

    modport master (
        output mclk,
        output sck,
        output lrck,
        output sdin
    );

    modport slave (
        input mclk,
        input sck,
        input lrck,
        input sdin
    );
endinterface

// File: rtl/drum_mix_i2s.sv
// -----------------------------------------------------------------------------
// drum_mix_i2s
//
// Purpose: once per 512-cycle frame, samples the four drum track outputs,
// drops any muted tracks, sums them, applies the master volume, saturates
// the result to 16 bits and serialises it MSB-first as an I2S stereo word
// (same value on left and right). Also generates the DAC clocks from a
// free-running frame counter.
//
// Ports:
//   clk          system clock (100 MHz)
//   rst_n        asynchronous active-low reset
//   audio_tom    signed 16-bit sample, tom track
//   audio_kick   signed 16-bit sample, kick track
//   audio_snare  signed 16-bit sample, snare track
//   audio_hat    signed 16-bit sample, hi-hat track
//   mute_mask    bit0 tom, bit1 kick, bit2 snare, bit3 hat; 1 forces track to 0
//   volume       master volume, 0 = silence, VOL_UNITY = unity gain
//   i2s          I2S bundle to the DAC (mclk, sck, lrck, sdin)
//   sample_tick  one-cycle pulse on the last cycle of each frame
//   clip         high for the whole frame whose word was saturated
// -----------------------------------------------------------------------------
module drum_mix_i2s #(
    parameter int DIV_W     = 9,
    parameter int VOL_UNITY = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic signed [15:0]    audio_tom,
    input  logic signed [15:0]    audio_kick,
    input  logic signed [15:0]    audio_snare,
    input  logic signed [15:0]    audio_hat,
    input  logic        [3:0]     mute_mask,
    input  logic        [2:0]     volume,
    drum_mix_i2s_if.master        i2s,
    output logic                  sample_tick,
    output logic                  clip
);

    localparam int VOL_SHIFT = $clog2(VOL_UNITY);

    logic        [DIV_W-1:0] div;
    logic signed [15:0]      tom_q;
    logic signed [15:0]      kick_q;
    logic signed [15:0]      snare_q;
    logic signed [15:0]      hat_q;
    logic        [2:0]       vol_q;
    logic signed [17:0]      sum_q;
    logic signed [20:0]      prod_c;
    logic signed [20:0]      scaled_q;
    logic signed [15:0]      word_c;
    logic                    sat_c;
    logic signed [15:0]      word_q;
    logic                    sat_q;
    logic        [31:0]      frame_sr;
    logic                    clip_q;

    logic capture_en;
    logic sum_en;
    logic scale_en;
    logic sat_en;
    logic load_en;
    logic shift_en;

    // Pipeline stages are keyed off the pre-edge frame counter value, so each
    // stage fires exactly once per frame in a fixed order.
    assign capture_en = (div == DIV_W'(0));
    assign sum_en     = (div == DIV_W'(1));
    assign scale_en   = (div == DIV_W'(2));
    assign sat_en     = (div == DIV_W'(3));
    assign load_en    = (div == DIV_W'(15));
    assign shift_en   = (div[3:0] == 4'hF);

    // Free-running frame counter; all DAC clocks are bits of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    // Input capture: muted tracks are replaced by zero at the capture point so
    // later stages never see them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tom_q   <= '0;
            kick_q  <= '0;
            snare_q <= '0;
            hat_q   <= '0;
            vol_q   <= '0;
        end else if (capture_en) begin
            tom_q   <= mute_mask[0] ? 16'sd0 : audio_tom;
            kick_q  <= mute_mask[1] ? 16'sd0 : audio_kick;
            snare_q <= mute_mask[2] ? 16'sd0 : audio_snare;
            hat_q   <= mute_mask[3] ? 16'sd0 : audio_hat;
            vol_q   <= volume;
        end
    end

    // Volume is unsigned, so it is zero-extended before the signed multiply.
    // Worst case |sum| * 7 fits in 21 signed bits.
    assign prod_c = 21'(sum_q) * $signed({18'd0, vol_q});

    // Sum, scale and hold stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q    <= '0;
            scaled_q <= '0;
            word_q   <= '0;
            sat_q    <= 1'b0;
        end else begin
            if (sum_en) begin
                sum_q <= 18'(tom_q) + 18'(kick_q) + 18'(snare_q) + 18'(hat_q);
            end
            if (scale_en) begin
                scaled_q <= prod_c >>> VOL_SHIFT;
            end
            if (sat_en) begin
                word_q <= word_c;
                sat_q  <= sat_c;
            end
        end
    end

    // Clamp the scaled value into the 16-bit signed range.
    always_comb begin
        word_c = scaled_q[15:0];
        sat_c  = 1'b0;
        if (scaled_q > 21'sd32767) begin
            word_c = 16'sh7FFF;
            sat_c  = 1'b1;
        end else if (scaled_q < -21'sd32768) begin
            word_c = 16'sh8000;
            sat_c  = 1'b1;
        end
    end

    // Serialiser: loading at div 0x00F gives the I2S one-bit delay after lrck
    // falls. The load takes priority over the shift that would otherwise
    // happen there, so R[0] stays on the line across the frame wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_sr <= '0;
            clip_q   <= 1'b0;
        end else if (load_en) begin
            frame_sr <= {word_q, word_q};
            clip_q   <= sat_q;
        end else if (shift_en) begin
            frame_sr <= {frame_sr[30:0], 1'b0};
        end
    end

    assign i2s.mclk    = div[1];
    assign i2s.sck     = div[3];
    assign i2s.lrck    = div[DIV_W-1];
    assign i2s.sdin    = frame_sr[31];
    assign sample_tick = &div;
    assign clip        = clip_q;

endmodule

// File: tb/tb_drum_mix_i2s.sv
// -----------------------------------------------------------------------------
// tb_drum_mix_i2s
//
// Purpose: directed bench for drum_mix_i2s. Keeps its own copy of the frame
// position, drives track samples, mask and volume, collects the 32 serial
// bits of each frame and compares them with hand-computed words.
// -----------------------------------------------------------------------------
module tb_drum_mix_i2s;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [15:0] audio_tom;
    logic signed [15:0] audio_kick;
    logic signed [15:0] audio_snare;
    logic signed [15:0] audio_hat;
    logic        [3:0]  mute_mask;
    logic        [2:0]  volume;
    logic               sample_tick;
    logic               clip;

    drum_mix_i2s_if i2s_bus ();

    drum_mix_i2s dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .audio_tom   (audio_tom),
        .audio_kick  (audio_kick),
        .audio_snare (audio_snare),
        .audio_hat   (audio_hat),
        .mute_mask   (mute_mask),
        .volume      (volume),
        .i2s         (i2s_bus),
        .sample_tick (sample_tick),
        .clip        (clip)
    );

    always #5 clk = ~clk;

    // Bench-side frame position: the value div will hold after each edge.
    logic [8:0] tb_div;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tb_div <= 9'd0;
        end else begin
            tb_div <= tb_div + 9'd1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [15:0] tom, input logic [15:0] kick,
                                  input logic [15:0] snare, input logic [15:0] hat,
                                  input logic [3:0] mask, input logic [2:0] vol);
        audio_tom   = tom;
        audio_kick  = kick;
        audio_snare = snare;
        audio_hat   = hat;
        mute_mask   = mask;
        volume      = vol;
    endtask

    // Advance to the next falling edge at which tb_div equals target.
    task automatic wait_div(input logic [8:0] target);
        do @(negedge clk); while (tb_div != target);
    endtask

    // Collect the 32 serial bits of the current frame, sampling each one in
    // the middle of its bit slot while sck is high. Optionally rewrites the
    // mute mask when the frame reaches chg_at.
    task automatic collect(output logic [31:0] bits, output logic clip_seen,
                           input int chg_at, input logic [3:0] chg_mask);
        logic [8:0] target;
        bits      = '0;
        clip_seen = 1'b0;
        for (int k = 0; k < 32; k++) begin
            target = 9'((32'h18 + 16 * k) & 32'h1FF);
            do begin
                @(negedge clk);
                if (chg_at >= 0 && tb_div == 9'(chg_at)) begin
                    mute_mask = chg_mask;
                end
            end while (tb_div != target);
            bits = {bits[30:0], i2s_bus.sdin};
            if (k == 0) begin
                clip_seen = clip;
            end
        end
    endtask

    // Wait for the capture edge that takes the current inputs, then check
    // the word serialised in that frame.
    task automatic check_output(input string tag, input logic [15:0] exp_word, input logic exp_clip);
        logic [31:0] bits;
        logic        clip_seen;
        wait_div(9'd1);
        collect(bits, clip_seen, -1, 4'b0000);
        check_value({tag, "_word"}, bits, {exp_word, exp_word});
        check_value({tag, "_clip"}, 32'(clip_seen), 32'(exp_clip));
    endtask

    initial begin
        logic [31:0] bits;
        logic        clip_seen;
        int          mclk_rises;
        int          sck_rises;
        int          lrck_rises;
        int          ticks;
        int          tick_bad;
        logic        mclk_prev;
        logic        sck_prev;
        logic        lrck_prev;

        rst_n = 1'b0;
        apply_stimulus(16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 3'd4);
        repeat (4) @(negedge clk);
        check_value("reset_outputs",
                    {26'd0, i2s_bus.sdin, clip, sample_tick, i2s_bus.mclk, i2s_bus.sck, i2s_bus.lrck},
                    32'd0);

        // One full frame after release: count clock edges and tick pulses.
        rst_n      = 1'b1;
        mclk_rises = 0;
        sck_rises  = 0;
        lrck_rises = 0;
        ticks      = 0;
        tick_bad   = 0;
        mclk_prev  = i2s_bus.mclk;
        sck_prev   = i2s_bus.sck;
        lrck_prev  = i2s_bus.lrck;
        for (int n = 0; n < 512; n++) begin
            @(negedge clk);
            if (i2s_bus.mclk && !mclk_prev) mclk_rises++;
            if (i2s_bus.sck && !sck_prev)   sck_rises++;
            if (i2s_bus.lrck && !lrck_prev) lrck_rises++;
            if (sample_tick) begin
                ticks++;
                if (tb_div != 9'h1FF) tick_bad++;
            end
            mclk_prev = i2s_bus.mclk;
            sck_prev  = i2s_bus.sck;
            lrck_prev = i2s_bus.lrck;
        end
        check_value("mclk_rises_per_frame", mclk_rises, 128);
        check_value("sck_rises_per_frame", sck_rises, 32);
        check_value("lrck_rises_per_frame", lrck_rises, 1);
        check_value("ticks_per_frame", ticks, 1);
        check_value("tick_position", tick_bad, 0);

        $display("[TB] silence and single track");
        check_output("zero_frame", 16'h0000, 1'b0);
        apply_stimulus(16'h1000, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 3'd4);
        check_output("tom_1000", 16'h1000, 1'b0);

        $display("[TB] saturation");
        apply_stimulus(16'h7000, 16'h7000, 16'h7000, 16'h7000, 4'b0000, 3'd4);
        check_output("sat_pos", 16'h7FFF, 1'b1);
        apply_stimulus(16'h9000, 16'h9000, 16'h9000, 16'h9000, 4'b0000, 3'd4);
        check_output("sat_neg", 16'h8000, 1'b1);

        $display("[TB] volume scaling");
        apply_stimulus(16'h0100, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 3'd7);
        check_output("vol7", 16'h01C0, 1'b0);
        apply_stimulus(16'h0100, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 3'd1);
        check_output("vol1", 16'h0040, 1'b0);
        apply_stimulus(16'h7000, 16'h7000, 16'h7000, 16'h7000, 4'b0000, 3'd0);
        check_output("vol0", 16'h0000, 1'b0);
        apply_stimulus(16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 3'd1);
        check_output("floor_neg", 16'hFFFF, 1'b0);

        $display("[TB] mute mask");
        apply_stimulus(16'h0000, 16'h4000, 16'h0000, 16'h0000, 4'b0010, 3'd4);
        wait_div(9'd1);
        collect(bits, clip_seen, 32'h080, 4'b0000);
        check_value("muted_kick", bits, 32'h0000_0000);
        collect(bits, clip_seen, -1, 4'b0000);
        check_value("unmuted_kick", bits, 32'h4000_4000);

        $display("[TB] reset mid-frame");
        apply_stimulus(16'h7000, 16'h7000, 16'h7000, 16'h7000, 4'b0000, 3'd4);
        wait_div(9'd1);
        wait_div(9'h0A0);
        check_value("pre_reset_sdin_clip", {30'd0, i2s_bus.sdin, clip}, 32'd3);
        rst_n = 1'b0;
        apply_stimulus(16'h1234, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 3'd4);
        #1;
        check_value("async_reset_outputs",
                    {26'd0, i2s_bus.sdin, clip, sample_tick, i2s_bus.mclk, i2s_bus.sck, i2s_bus.lrck},
                    32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_output("post_reset", 16'h1234, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/drum_mix_i2s.md
Name: drum_mix_i2s

Overview:
- Downstream of the per-instrument track iterators (tom, kick, snare, hi-hat); consumes their 16-bit `audio` outputs.
- Each frame: samples all four tracks once, applies a per-track mute mask, sums them, scales by master volume and saturates to 16 bits.
- Serialises the result MSB-first as an I2S stereo stream (same word on L and R) to the Pmod I2S DAC.
- Generates the DAC clocks (mclk, lrck, sck) from the system clock.

Parameters:
- DIV_W, 9, frame counter width. One frame is 2^DIV_W clk cycles; fixed at 9 for the 32-bit sck frame.
- VOL_UNITY, 4, volume code giving unity gain; scaling shift is log2(VOL_UNITY)=2.

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous active-low reset
- audio_tom  in  16  signed sample, tom track iterator
- audio_kick  in  16  signed sample, kick track iterator
- audio_snare  in  16  signed sample, snare track iterator
- audio_hat  in  16  signed sample, hi-hat track iterator
- mute_mask  in  4  bit0 tom, bit1 kick, bit2 snare, bit3 hat; 1 = track forced to 0
- volume  in  3  master volume; 0 = silence, 4 = unity
- mclk  out  1  div[1] (clk/4)
- sck  out  1  div[3] (clk/16)
- lrck  out  1  div[8] (clk/512); 0 = left half, 1 = right half
- sdin  out  1  serial data
- sample_tick  out  1  one-cycle pulse when div==0x1FF (last cycle of frame)
- clip  out  1  high for the whole frame whose word saturated

Behaviour:
- Reset (async, rst_n=0):
  - div=0; all pipeline and shift registers=0.
  - sdin=0, clip=0, sample_tick=0; mclk/sck/lrck=0, since they are derived from div.
- div is a free-running 9-bit counter, +1 every clk, wraps 0x1FF->0x000.
- Capture pipeline (all on clk edges, div values are pre-edge):
  - div==0x000: register the four inputs, each zeroed if its mute_mask bit is set; register volume.
  - div==0x001: sum = sign-extended 18-bit sum of the four captured values. Range -131072..131068; no overflow possible.
  - div==0x002: prod = sum * volume (volume unsigned 3-bit), held in 21 bits signed; scaled = prod >>> 2 (arithmetic shift, floor toward -inf).
  - div==0x003: word = saturate(scaled) to [-32768, 32767]; sat flag = 1 if clamped.
  - Input changes between capture points have no effect until the next frame.
- Serialiser:
  - At the edge where div==0x00F: frame_sr[31:0] <= {word, word}; sdin <= word[15]; clip <= sat flag.
  - At every subsequent edge where div[3:0]==0xF: shift frame_sr left; sdin <= next bit.
  - sdin therefore changes coincident with each sck falling edge and is stable through sck high.
  - L MSB is valid one sck period after lrck falls; R MSB is valid one sck period after lrck rises (I2S one-bit delay).
  - Bit order: L[15..0] driven from div 0x00F..0x0FF, R[15..0] from div 0x10F..0x1FF.
  - R[0] is held across the frame wrap until div==0x00F of the next frame.
- Latency: inputs captured at div 0 of frame N appear on sdin from div 0x00F of frame N (MSB).
- volume==0: word=0, sat=0 regardless of inputs. volume==7 gives gain 1.75.
- All four tracks muted: word=0.
- sample_tick: single-cycle pulse at div==0x1FF. Upstream may update samples on it; they are captured on the next cycle.
- Reset mid-frame:
  - Outputs go to reset values immediately; the partial word is lost.
  - After release, div restarts at 0; the first full frame carries the sample captured at div 0 after release.
  - No glitch pulse on sample_tick during or on exit from reset.

Test Plan:
- Reset release, all inputs 0, volume=4 -> mclk/sck/lrck periods 4/16/512 clks; sdin=0 for the full frame; sample_tick every 512 clks at div 0x1FF.
- tom=0x1000, others 0, volume=4, mask=0 -> word 0x1000. Serial bits at div 0x00F..0x0FF = 0001_0000_0000_0000, repeated for R; clip=0.
- All four = 0x7000, volume=4 -> sum 0x1C000, saturates to 0x7FFF, clip=1 for that frame. All four = 0x9000 -> 0x8000, clip=1.
- tom=0x0100, volume=7 -> word 0x01C0. Same input with volume=1 -> 0x0040. volume=0 -> 0x0000.
- kick=0x4000, mute_mask=4'b0010 -> word 0. Clear the mask mid-frame (div 0x080) -> current frame still 0, next frame 0x4000.
- Assert rst_n=0 at div 0x0A0 mid-word -> sdin, clip and div go to 0 asynchronously. Release with tom=0x1234, volume=4 -> first frame after release serialises 0x1234 on L and R.
